// File: rtl/mux_scan_collector.sv
// Scan sequencer and snapshot collector for a 32:1 x 2-bit channel mux.
// Steps the mux select through every channel, one per clock. It records each
// sample, then presents the assembled snapshot on a valid/ready port together
// with a per-channel change mask relative to the last accepted snapshot.
//
// Handshake: snap_valid rises at the end of a scan and stays high with
// snap_data/changed frozen until a rising clk edge samples snap_ready=1. At
// that edge the snapshot is consumed and snap_valid falls. snap_ready has no
// effect while snap_valid is low.
module mux_scan_collector #(
  parameter int NUM_CH = 32,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [SEL_W-1:0]         sel,
  input  logic [DATA_W-1:0]        mux_out,
  output logic                     busy,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [NUM_CH*DATA_W-1:0] snap_data,
  output logic [NUM_CH-1:0]        changed,
  output logic                     start_ovr,
  output logic [1:0]               fsm_state
);

  localparam int SNAP_W = NUM_CH * DATA_W;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state;
  logic [SNAP_W-1:0]   cap_buf;    // samples gathered during the current scan
  logic [SNAP_W-1:0]   prev_snap;  // last snapshot the consumer accepted
  logic [SNAP_W-1:0]   scan_word;  // completed snapshot at the final scan edge
  logic [NUM_CH-1:0]   scan_diff;  // per-channel change mask for scan_word

  assign fsm_state = state;
  assign busy      = (state != IDLE);

  // Final snapshot: the last channel comes straight from the mux, because its
  // buffer slot is only written at the same edge that publishes the snapshot.
  always_comb begin
    scan_word = cap_buf;
    scan_word[SNAP_W-1 -: DATA_W] = mux_out;
    scan_diff = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_diff[i] = |(scan_word[i*DATA_W +: DATA_W] ^ prev_snap[i*DATA_W +: DATA_W]);
    end
  end

  // Scan/hold sequencer with its capture, snapshot and overrun registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= '0;
      cap_buf    <= '0;
      prev_snap  <= '0;
      snap_data  <= '0;
      changed    <= '0;
      snap_valid <= 1'b0;
      start_ovr  <= 1'b0;
    end else begin
      // A start request that cannot be honoured is flagged for one cycle.
      start_ovr <= start && (state != IDLE);
      case (state)
        IDLE: begin
          sel <= '0;
          if (start) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
              cap_buf[i*DATA_W +: DATA_W] <= mux_out;
            end
          end
          if (sel == LAST_SEL) begin
            snap_data  <= scan_word;
            changed    <= scan_diff;
            snap_valid <= 1'b1;
            sel        <= '0;
            state      <= HOLD;
          end else begin
            sel <= sel + 1'b1;
          end
        end
        HOLD: begin
          sel <= '0;
          if (snap_ready) begin
            prev_snap  <= snap_data;
            snap_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          sel        <= '0;
          snap_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_collector.sv
// Bench for mux_scan_collector: directed scans against a behavioural 32:1 mux.
// Expected snapshots are queued when each scan is started, and the monitor
// compares them when snap_valid rises.
module tb_mux_scan_collector;

  localparam int NUM_CH = 32;
  localparam int SEL_W  = 5;
  localparam int DATA_W = 2;

  localparam logic [63:0] DATA_BASE = 64'hE4E4_E4E4_E4E4_E4E4;
  localparam logic [63:0] DATA_CH5  = 64'hE4E4_E4E4_E4E4_E8E4;
  localparam logic [31:0] CHG_BASE  = 32'hEEEE_EEEE;
  localparam int NO_OVR = 99;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        mux_out;
  logic                     busy;
  logic                     snap_valid;
  logic                     snap_ready = 1'b0;
  logic [NUM_CH*DATA_W-1:0] snap_data;
  logic [NUM_CH-1:0]        changed;
  logic                     start_ovr;
  logic [1:0]               fsm_state;

  logic [DATA_W-1:0] ch [NUM_CH];
  logic [95:0]       exp_q[$];
  int                checks = 0;
  int                errors = 0;
  logic              valid_d = 1'b0;

  mux_scan_collector #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .mux_out(mux_out),
    .busy(busy), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_data(snap_data), .changed(changed), .start_ovr(start_ovr),
    .fsm_state(fsm_state)
  );

  // clock / behavioural mux
  always #5 clk = ~clk;
  assign mux_out = ch[sel];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_base;
    for (int i = 0; i < NUM_CH; i++) ch[i] = DATA_W'(i % 4);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " sel"}, 64'(sel), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " snap_valid"}, 64'(snap_valid), 64'd0);
    chk({tag, " snap_data"}, snap_data, 64'd0);
    chk({tag, " changed"}, 64'(changed), 64'd0);
    chk({tag, " start_ovr"}, 64'(start_ovr), 64'd0);
  endtask

  // Start a scan in IDLE, queue its expected snapshot, step the 32 scan cycles
  // and leave the caller in the first HOLD cycle. ovr_iter injects a start
  // during scan iteration ovr_iter (scan cycle ovr_iter+1).
  task automatic run_scan(input logic rdy, input int ovr_iter, input logic [63:0] exp_data,
                          input logic [31:0] exp_chg);
    exp_q.push_back({exp_chg, exp_data});
    start = 1'b1;
    snap_ready = rdy;
    tick;
    start = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("scan sel[%0d]", i), 64'(sel), 64'(i));
      chk($sformatf("scan busy[%0d]", i), 64'(busy), 64'd1);
      chk($sformatf("scan valid[%0d]", i), 64'(snap_valid), 64'd0);
      chk($sformatf("scan start_ovr[%0d]", i), 64'(start_ovr), 64'(i == ovr_iter + 1));
      if (i == ovr_iter) start = 1'b1;
      tick;
      start = 1'b0;
    end
    chk("end valid", 64'(snap_valid), 64'd1);
    chk("end sel", 64'(sel), 64'd0);
    chk("end busy", 64'(busy), 64'd1);
  endtask

  // monitor: compare each new snapshot against the scoreboard
  always @(negedge clk) begin
    if (snap_valid && !valid_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected snapshot: got %h with no expected entry", snap_data);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("mon snap_data", snap_data, e[63:0]);
        chk("mon changed", 64'(changed), 64'(e[95:64]));
      end
    end
    valid_d = snap_valid;
  end

  initial begin
    set_base;
    // reset state
    tick;
    tick;
    chk_cleared("reset");
    chk("reset state", 64'(fsm_state), 64'd0);
    reset = 1'b0;
    tick;

    // basic scan, then backpressure with the mux inputs moving underneath
    run_scan(1'b0, NO_OVR, DATA_BASE, CHG_BASE);
    for (int i = 0; i < NUM_CH; i++) ch[i] = 2'd3;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("bp valid", 64'(snap_valid), 64'd1);
      chk("bp data", snap_data, DATA_BASE);
      chk("bp changed", 64'(changed), 64'(CHG_BASE));
      chk("bp sel", 64'(sel), 64'd0);
    end
    snap_ready = 1'b1;
    tick;
    snap_ready = 1'b0;
    chk("accept valid", 64'(snap_valid), 64'd0);
    chk("accept busy", 64'(busy), 64'd0);
    chk("idle keeps data", snap_data, DATA_BASE);
    tick;

    // change detect: only channel 5 flips 01 -> 10; ready held high all scan
    set_base;
    ch[5] = 2'b10;
    run_scan(1'b1, NO_OVR, DATA_CH5, 32'h0000_0020);
    tick;
    snap_ready = 1'b0;
    chk("auto accept valid", 64'(snap_valid), 64'd0);
    chk("auto accept data", snap_data, DATA_CH5);
    tick;

    // overrun: second start at cycle 10 of the scan, then start+ready in HOLD
    set_base;
    run_scan(1'b0, 9, DATA_BASE, 32'h0000_0020);
    start = 1'b1;
    snap_ready = 1'b1;
    tick;
    start = 1'b0;
    snap_ready = 1'b0;
    chk("collide valid", 64'(snap_valid), 64'd0);
    chk("collide busy", 64'(busy), 64'd0);
    chk("collide start_ovr", 64'(start_ovr), 64'd1);
    tick;
    chk("ovr pulse end", 64'(start_ovr), 64'd0);
    chk("ovr still idle", 64'(busy), 64'd0);

    // normal scan after the collision; left unaccepted, then reset in HOLD
    run_scan(1'b0, NO_OVR, DATA_BASE, 32'h0);
    tick;
    chk("unaccepted valid", 64'(snap_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk_cleared("reset hold");
    tick;
    reset = 1'b0;
    tick;
    run_scan(1'b0, NO_OVR, DATA_BASE, CHG_BASE);
    snap_ready = 1'b1;
    tick;
    snap_ready = 1'b0;
    tick;

    // reset mid-scan at sel=17, then a full scan from channel 0
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 17; k++) tick;
    chk("mid sel", 64'(sel), 64'd17);
    reset = 1'b1;
    #1;
    chk_cleared("reset scan");
    tick;
    reset = 1'b0;
    tick;
    run_scan(1'b0, NO_OVR, DATA_BASE, CHG_BASE);
    snap_ready = 1'b1;
    tick;
    snap_ready = 1'b0;
    tick;
    tick;

    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
